note_sample_mixer: RTL

NOTE_SAMPLE_MIXER -- requirements
Module: note_sample_mixer

---
 rtl/note_sample_mixer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/note_sample_mixer.sv
// note_sample_mixer: once per codec sample tick, fetches one signed byte per enabled
// note region from flash, sums them, and emits the scaled mix. A shared sample
// pointer advances each frame until it reaches PTR_END and then parks.
module note_sample_mixer #(
    parameter logic [15:0] PTR_END = 16'hFFFF,
    parameter int unsigned SHIFT   = 5
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [7:0]  i_music_enb,
    input  logic        i_note_rst,
    input  logic        i_sample_tick,
    output logic        o_flash_rd,
    output logic [18:0] o_flash_addr,
    input  logic [7:0]  i_flash_data,
    input  logic        i_flash_ack,
    output logic [15:0] o_audio,
    output logic        o_audio_valid,
    output logic        o_flash_valid,
    output logic        o_overrun
);

    typedef enum logic [1:0] {StIdle, StScan, StRead, StDone} state_t;

    state_t      state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic        finished_q, finished_d;
    logic        rst_pend_q, rst_pend_d;
    logic [10:0] acc_q, acc_d;
    logic [7:0]  enb_q, enb_d;
    logic [3:0]  idx_q, idx_d;
    logic        flash_rd_q, flash_rd_d;
    logic [18:0] flash_addr_q, flash_addr_d;
    logic [15:0] audio_q, audio_d;
    logic        audio_valid_q, audio_valid_d;
    logic        flash_valid_q, flash_valid_d;
    logic        overrun_q, overrun_d;

    logic [15:0] acc_ext;
    logic [10:0] data_ext;

    assign acc_ext  = {{5{acc_q[10]}}, acc_q};
    assign data_ext = {{3{i_flash_data[7]}}, i_flash_data};

    // Next-state logic: frame sequencing, accumulation and pointer bookkeeping
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        finished_d    = finished_q;
        rst_pend_d    = rst_pend_q;
        acc_d         = acc_q;
        enb_d         = enb_q;
        idx_d         = idx_q;
        flash_rd_d    = flash_rd_q;
        flash_addr_d  = flash_addr_q;
        audio_d       = audio_q;
        audio_valid_d = 1'b0;
        flash_valid_d = 1'b0;
        overrun_d     = overrun_q;

        // Outside IDLE a restart is deferred to the end of the frame and ticks are lost
        if (state_q != StIdle) begin
            if (i_note_rst) begin
                rst_pend_d = 1'b1;
            end
            if (i_sample_tick) begin
                overrun_d = 1'b1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (i_note_rst) begin
                    ptr_d      = 16'd0;
                    finished_d = 1'b0;
                    rst_pend_d = 1'b0;
                end
                if (i_sample_tick) begin
                    enb_d   = i_music_enb;
                    acc_d   = 11'd0;
                    idx_d   = 4'd0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (idx_q == 4'd8) begin
                    // Outputs are loaded on entry so the pulses coincide with DONE
                    audio_d       = acc_ext << SHIFT;
                    audio_valid_d = 1'b1;
                    flash_valid_d = 1'b1;
                    state_d       = StDone;
                end else if (enb_q[idx_q[2:0]] && !finished_q) begin
                    // ptr never exceeds PTR_END (it parks there), so no range test is needed
                    flash_rd_d   = 1'b1;
                    flash_addr_d = {idx_q[2:0], ptr_q};
                    state_d      = StRead;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StRead: begin
                if (i_flash_ack) begin
                    acc_d      = acc_q + data_ext;
                    flash_rd_d = 1'b0;
                    idx_d      = idx_q + 4'd1;
                    state_d    = StScan;
                end
            end
            StDone: begin
                if (rst_pend_q) begin
                    ptr_d      = 16'd0;
                    finished_d = 1'b0;
                end else if (ptr_q == PTR_END) begin
                    finished_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + 16'd1;
                end
                rst_pend_d = i_note_rst;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous reset
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q       <= StIdle;
            ptr_q         <= 16'd0;
            finished_q    <= 1'b0;
            rst_pend_q    <= 1'b0;
            acc_q         <= 11'd0;
            enb_q         <= 8'd0;
            idx_q         <= 4'd0;
            flash_rd_q    <= 1'b0;
            flash_addr_q  <= 19'd0;
            audio_q       <= 16'd0;
            audio_valid_q <= 1'b0;
            flash_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            finished_q    <= finished_d;
            rst_pend_q    <= rst_pend_d;
            acc_q         <= acc_d;
            enb_q         <= enb_d;
            idx_q         <= idx_d;
            flash_rd_q    <= flash_rd_d;
            flash_addr_q  <= flash_addr_d;
            audio_q       <= audio_d;
            audio_valid_q <= audio_valid_d;
            flash_valid_q <= flash_valid_d;
            overrun_q     <= overrun_d;
        end
    end

    assign o_flash_rd    = flash_rd_q;
    assign o_flash_addr  = flash_addr_q;
    assign o_audio       = audio_q;
    assign o_audio_valid = audio_valid_q;
    assign o_flash_valid = flash_valid_q;
    assign o_overrun     = overrun_q;

endmodule
